// File: rtl/bomb_manager.sv
// bomb_manager: three bomb slots with tick-driven fuses and a registered valid/ready
// event port that reports each detonation once to the map-update stage.
module bomb_manager #(
  parameter int NUM_ROW      = 11,
  parameter int NUM_COL      = 19,
  parameter int TILE_PX      = 64,
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 48,
  parameter int BOMB_TIME    = 3,
  parameter int EXPLODE_TIME = 1,
  localparam int ADDR_WIDTH  = $clog2(NUM_ROW*NUM_COL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  place_req,
  input  logic [10:0]           player_x,
  input  logic [9:0]            player_y,
  input  logic [1:0]            max_bombs,
  input  logic [1:0]            bomb_range,
  output logic [ADDR_WIDTH-1:0] bomb_addr [0:2],
  output logic                  bomb_active [0:2],
  output logic                  explode_active [0:2],
  output logic [1:0]            bomb_count,
  output logic                  expl_valid,
  output logic [ADDR_WIDTH-1:0] expl_addr,
  output logic [1:0]            expl_range,
  input  logic                  expl_ready
);
  localparam int NS      = 3;
  localparam int TILE_SH = $clog2(TILE_PX);
  localparam int TMAX    = (BOMB_TIME > EXPLODE_TIME) ? BOMB_TIME : EXPLODE_TIME;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODING} slot_state_t;

  slot_state_t           st [NS];
  slot_state_t           st_nxt [NS];
  logic [ADDR_WIDTH-1:0] addr [NS];
  logic [ADDR_WIDTH-1:0] addr_nxt [NS];
  logic [1:0]            rng [NS];
  logic [1:0]            rng_nxt [NS];
  logic [TW-1:0]         tmr [NS];
  logic [TW-1:0]         tmr_nxt [NS];
  logic                  pend [NS];
  logic                  pend_nxt [NS];

  logic [1:0]            ev_slot, ev_slot_nxt;
  logic                  ev_valid_nxt;
  logic [ADDR_WIDTH-1:0] ev_addr_nxt;
  logic [1:0]            ev_rng_nxt;

  logic [31:0]           col, row;
  logic [ADDR_WIDTH-1:0] tile;
  logic [1:0]            cnt, free_idx, pick;
  logic                  dup, free_ok, pick_ok, accept, xfer;

  // Tile of the sprite centre, formed at 32 bits and only then truncated.
  assign col  = (32'(player_x) + 32'(SPRITE_W/2)) >> TILE_SH;
  assign row  = (32'(player_y) + 32'(SPRITE_H/2)) >> TILE_SH;
  assign tile = ADDR_WIDTH'(row * 32'(NUM_COL) + col);

  always_comb begin
    cnt      = '0;
    dup      = 1'b0;
    free_idx = '0;
    free_ok  = 1'b0;
    pick     = '0;
    pick_ok  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (st[i] != IDLE) begin
        cnt = cnt + 2'd1;
        if (addr[i] == tile) dup = 1'b1;
      end else if (!free_ok) begin
        free_idx = 2'(i);
        free_ok  = 1'b1;
      end
      if (pend[i] && !pick_ok) begin
        pick    = 2'(i);
        pick_ok = 1'b1;
      end
    end
    accept = place_req && free_ok && (cnt < max_bombs) && !dup;
    xfer   = expl_valid && expl_ready;
  end

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      st_nxt[i]   = st[i];
      addr_nxt[i] = addr[i];
      rng_nxt[i]  = rng[i];
      tmr_nxt[i]  = tmr[i];
      pend_nxt[i] = pend[i] && !(xfer && ev_slot == 2'(i));
      case (st[i])
        IDLE: begin
          // A freshly loaded slot ignores any tick seen in its load cycle.
          if (accept && free_idx == 2'(i)) begin
            st_nxt[i]   = ARMED;
            addr_nxt[i] = tile;
            rng_nxt[i]  = bomb_range;
            tmr_nxt[i]  = TW'(BOMB_TIME);
            pend_nxt[i] = 1'b0;
          end
        end
        ARMED: begin
          if (tick) begin
            if (tmr[i] == TW'(1)) begin
              st_nxt[i]   = EXPLODING;
              tmr_nxt[i]  = TW'(EXPLODE_TIME);
              pend_nxt[i] = 1'b1;
            end else begin
              tmr_nxt[i] = tmr[i] - TW'(1);
            end
          end
        end
        EXPLODING: begin
          // Held until both the flame time has run out and the event is delivered.
          if (!pend[i] && tmr[i] == '0) begin
            st_nxt[i]   = IDLE;
            addr_nxt[i] = '0;
            rng_nxt[i]  = '0;
          end else if (tick && tmr[i] != '0) begin
            tmr_nxt[i] = tmr[i] - TW'(1);
          end
        end
        default: begin
          st_nxt[i]   = IDLE;
          addr_nxt[i] = '0;
          rng_nxt[i]  = '0;
          tmr_nxt[i]  = '0;
          pend_nxt[i] = 1'b0;
        end
      endcase
    end

    ev_valid_nxt = expl_valid;
    ev_addr_nxt  = expl_addr;
    ev_rng_nxt   = expl_range;
    ev_slot_nxt  = ev_slot;
    if (xfer) begin
      ev_valid_nxt = 1'b0;
    end else if (!expl_valid && pick_ok) begin
      ev_valid_nxt = 1'b1;
      ev_addr_nxt  = addr[pick];
      ev_rng_nxt   = rng[pick];
      ev_slot_nxt  = pick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        st[i]   <= IDLE;
        addr[i] <= '0;
        rng[i]  <= '0;
        tmr[i]  <= '0;
        pend[i] <= 1'b0;
      end
      expl_valid <= 1'b0;
      expl_addr  <= '0;
      expl_range <= '0;
      ev_slot    <= '0;
    end else begin
      st         <= st_nxt;
      addr       <= addr_nxt;
      rng        <= rng_nxt;
      tmr        <= tmr_nxt;
      pend       <= pend_nxt;
      expl_valid <= ev_valid_nxt;
      expl_addr  <= ev_addr_nxt;
      expl_range <= ev_rng_nxt;
      ev_slot    <= ev_slot_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      bomb_addr[i]      = addr[i];
      bomb_active[i]    = (st[i] == ARMED);
      explode_active[i] = (st[i] == EXPLODING);
    end
  end

  assign bomb_count = cnt;

endmodule

// File: tb/tb_bomb_manager.sv
// Bench for bomb_manager: directed scenarios then random traffic, checked against a
// slot-level reference model with an event scoreboard matched on delivery.
module tb_bomb_manager;
  localparam int NUM_ROW = 11, NUM_COL = 19, TILE_PX = 64, SPRITE_W = 32, SPRITE_H = 48;
  localparam int BOMB_TIME = 3, EXPLODE_TIME = 1;
  localparam int AW = $clog2(NUM_ROW*NUM_COL);

  logic          clk = 1'b0;
  logic          rst, tick, place_req, expl_ready;
  logic [10:0]   player_x;
  logic [9:0]    player_y;
  logic [1:0]    max_bombs, bomb_range;
  logic [AW-1:0] bomb_addr [0:2];
  logic          bomb_active [0:2];
  logic          explode_active [0:2];
  logic [1:0]    bomb_count;
  logic          expl_valid;
  logic [AW-1:0] expl_addr;
  logic [1:0]    expl_range;

  bomb_manager #(
    .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .TILE_PX(TILE_PX), .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H), .BOMB_TIME(BOMB_TIME), .EXPLODE_TIME(EXPLODE_TIME)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .place_req(place_req),
    .player_x(player_x), .player_y(player_y), .max_bombs(max_bombs), .bomb_range(bomb_range),
    .bomb_addr(bomb_addr), .bomb_active(bomb_active), .explode_active(explode_active),
    .bomb_count(bomb_count), .expl_valid(expl_valid), .expl_addr(expl_addr),
    .expl_range(expl_range), .expl_ready(expl_ready)
  );

  always #5 clk = ~clk;

  // st: 0 idle, 1 armed, 2 exploding
  typedef struct {int st; int addr; int rng; int tmr; bit pend;} slot_t;
  typedef struct {int addr; int rng; int slot;} ev_t;

  slot_t m [3];
  ev_t   exp_q [$];
  int    dlv_q [$];
  int    n_vec = 0, n_err = 0, hs_slot = -1;
  bit    prev_v = 1'b0;
  int    prev_a = 0, prev_r = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs the DUT just sampled.
  task automatic model_step(input int hs);
    int tile, cnt, fr;
    bit dup;
    slot_t n [3];
    if (rst) begin
      foreach (m[i]) m[i] = '{0, 0, 0, 0, 1'b0};
      exp_q.delete();
      return;
    end
    tile = (((int'(player_y) + SPRITE_H/2) / TILE_PX) * NUM_COL
            + (int'(player_x) + SPRITE_W/2) / TILE_PX) % (1 << AW);
    cnt = 0; dup = 1'b0; fr = -1;
    for (int i = 0; i < 3; i++) begin
      if (m[i].st != 0) begin
        cnt++;
        if (m[i].addr == tile) dup = 1'b1;
      end else if (fr < 0) fr = i;
    end
    n = m;
    if (hs >= 0) n[hs].pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m[i].st == 1 && tick) begin
        if (m[i].tmr == 1) begin
          n[i].st = 2; n[i].tmr = EXPLODE_TIME; n[i].pend = 1'b1;
          exp_q.push_back('{m[i].addr, m[i].rng, i});
        end else n[i].tmr--;
      end else if (m[i].st == 2) begin
        if (m[i].tmr == 0 && !m[i].pend) n[i] = '{0, 0, 0, 0, 1'b0};
        else if (tick && m[i].tmr > 0) n[i].tmr--;
      end
    end
    if (place_req && cnt < int'(max_bombs) && !dup && fr >= 0)
      n[fr] = '{1, tile, int'(bomb_range), BOMB_TIME, 1'b0};
    m = n;
  endtask

  task automatic check_outputs();
    int cnt = 0;
    foreach (m[i]) if (m[i].st != 0) cnt++;
    chk("bomb_count", int'(bomb_count), cnt);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bomb_active[%0d]", i), int'(bomb_active[i]), int'(m[i].st == 1));
      chk($sformatf("explode_active[%0d]", i), int'(explode_active[i]), int'(m[i].st == 2));
      chk($sformatf("bomb_addr[%0d]", i), int'(bomb_addr[i]), m[i].addr);
    end
    if (expl_valid) chk("valid_has_event", int'(exp_q.size() > 0), 1);
    if (!rst && prev_v && !expl_ready) begin
      chk("hold_valid", int'(expl_valid), 1);
      chk("hold_addr", int'(expl_addr), prev_a);
      chk("hold_range", int'(expl_range), prev_r);
    end
    prev_v = expl_valid;
    prev_a = int'(expl_addr);
    prev_r = int'(expl_range);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step(hs_slot);
    check_outputs();
  endtask

  // Monitor: every handshake must match exactly one outstanding detonation.
  always @(negedge clk) begin : mon
    int k;
    hs_slot = -1;
    if (expl_valid === 1'b1 && expl_ready === 1'b1) begin
      k = -1;
      foreach (exp_q[j]) if (k < 0 && exp_q[j].addr == int'(expl_addr)) k = j;
      chk("event_known", int'(k >= 0), 1);
      if (k >= 0) begin
        chk("event_range", int'(expl_range), exp_q[k].rng);
        hs_slot = exp_q[k].slot;
        exp_q.delete(k);
      end
      dlv_q.push_back(int'(expl_addr));
    end
  end

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic wait_valid(input string nm);
    int c = 0;
    while (!expl_valid && c < 10) begin step(); c++; end
    chk(nm, int'(expl_valid), 1);
  endtask

  task automatic flush();
    int c = 0;
    expl_ready = 1'b1; place_req = 1'b0;
    while (c < 60) begin
      if (bomb_count == 0 && !expl_valid && exp_q.size() == 0) break;
      tick = (c % 2 == 0);
      step();
      c++;
    end
    tick = 1'b0;
    chk("flush_count", int'(bomb_count), 0);
  endtask

  task automatic set_pos(input int x, input int y);
    player_x = 11'(x); player_y = 10'(y);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; tick = 1'b0; place_req = 1'b0; expl_ready = 1'b0;
    player_x = '0; player_y = '0; max_bombs = '0; bomb_range = '0;
    step();
    rst = 1'b0;
    chk("rst_valid", int'(expl_valid), 0);
    chk("rst_eaddr", int'(expl_addr), 0);
    chk("rst_erange", int'(expl_range), 0);

    // Single bomb: placement, fuse, event.
    max_bombs = 2'd1; bomb_range = 2'd2; set_pos(100, 50);
    place_req = 1'b1; step(); place_req = 1'b0;
    chk("t1_addr0", int'(bomb_addr[0]), 20);
    chk("t1_count", int'(bomb_count), 1);
    repeat (3) tick_pulse();
    chk("t1_expl0", int'(explode_active[0]), 1);
    wait_valid("t1_valid");
    chk("t1_eaddr", int'(expl_addr), 20);
    chk("t1_erange", int'(expl_range), 2);
    flush();

    // Limit blocks placement; raising the limit admits the next tile.
    do_reset();
    max_bombs = 2'd1; set_pos(100, 50);
    place_req = 1'b1; step();
    set_pos(228, 50); step(); place_req = 1'b0;
    chk("t2_blocked", int'(bomb_count), 1);
    max_bombs = 2'd2; place_req = 1'b1; step(); place_req = 1'b0;
    chk("t2_addr1", int'(bomb_addr[1]), 22);
    chk("t2_active1", int'(bomb_active[1]), 1);
    flush();

    // Held request on one tile gives one bomb.
    do_reset();
    max_bombs = 2'd3; set_pos(100, 50); place_req = 1'b1;
    repeat (10) step();
    place_req = 1'b0;
    chk("t3_count", int'(bomb_count), 1);
    chk("t3_active1", int'(bomb_active[1]), 0);

    // Simultaneous detonations under back-pressure.
    do_reset();
    dlv_q.delete();
    expl_ready = 1'b0; max_bombs = 2'd2; bomb_range = 2'd1;
    set_pos(100, 50); place_req = 1'b1; step();
    set_pos(228, 50); step(); place_req = 1'b0;
    repeat (3) tick_pulse();
    wait_valid("t4_valid");
    repeat (5) begin
      step();
      chk("t4_stall_addr", int'(expl_addr), 20);
    end
    expl_ready = 1'b1;
    begin
      int c = 0;
      while (dlv_q.size() < 2 && c < 20) begin step(); c++; end
    end
    chk("t4_nevents", dlv_q.size(), 2);
    if (dlv_q.size() >= 2) begin
      chk("t4_first", dlv_q[0], 20);
      chk("t4_second", dlv_q[1], 22);
    end
    chk("t4_still_expl0", int'(explode_active[0]), 1);
    flush();
    chk("t4_no_dup", dlv_q.size(), 2);

    // Placement in a tick cycle is not decremented by that tick.
    do_reset();
    max_bombs = 2'd1; set_pos(100, 50);
    place_req = 1'b1; tick = 1'b1; step();
    place_req = 1'b0; tick = 1'b0; step();
    chk("t5_armed", int'(bomb_active[0]), 1);
    repeat (2) tick_pulse();
    chk("t5_not_yet", int'(explode_active[0]), 0);
    tick_pulse();
    chk("t5_expl", int'(explode_active[0]), 1);
    flush();

    // Reset with armed bombs and a pending event.
    do_reset();
    expl_ready = 1'b0; max_bombs = 2'd3; set_pos(100, 50);
    place_req = 1'b1; step(); place_req = 1'b0;
    repeat (2) tick_pulse();
    set_pos(228, 50); place_req = 1'b1; step();
    set_pos(356, 50); step(); place_req = 1'b0;
    tick_pulse();
    wait_valid("t6_valid");
    chk("t6_armed2", int'(bomb_active[2]), 1);
    do_reset();
    chk("t6_valid0", int'(expl_valid), 0);
    chk("t6_eaddr0", int'(expl_addr), 0);
    chk("t6_count0", int'(bomb_count), 0);
    base = dlv_q.size();
    expl_ready = 1'b1;
    repeat (5) tick_pulse();
    chk("t6_no_events", dlv_q.size(), base);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 399) == 0);
      tick      = ($urandom_range(0, 5) == 0);
      place_req = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       begin player_x = 11'($urandom); player_y = 10'($urandom); end
        1, 2, 3, 4: set_pos(int'($urandom_range(0, 3)) * 64, int'($urandom_range(0, 2)) * 64);
        default: set_pos(int'($urandom_range(0, 1199)), int'($urandom_range(0, 687)));
      endcase
      if (cyc % 40 == 0) max_bombs = 2'($urandom_range(0, 3));
      bomb_range = 2'($urandom);
      expl_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    flush();
    chk("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bomb_manager.md
BOMB_MANAGER -- requirements
Module: bomb_manager

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_ROW, 11, map rows.
- NUM_COL, 19, map columns.
- TILE_PX, 64, tile size in pixels (power of two).
- SPRITE_W, 32, player sprite width.
- SPRITE_H, 48, player sprite height.
- BOMB_TIME, 3, ticks from placement to detonation (>=1).
- EXPLODE_TIME, 1, ticks an explosion stays active (>=1).
- ADDR_WIDTH (local), $clog2(NUM_ROW*NUM_COL), tile address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle timebase pulse.
- place_req  in  1  player requests a bomb; level-sampled each cycle.
- player_x  in  11  player map x, pixels.
- player_y  in  10  player map y, pixels.
- max_bombs  in  2  allowed concurrent bombs, 0..3.
- bomb_range  in  2  explosion range in tiles.
- bomb_addr[0:2]  out  ADDR_WIDTH each  tile of each slot.
- bomb_active[0:2]  out  1 each  slot is ARMED.
- explode_active[0:2]  out  1 each  slot is EXPLODING.
- bomb_count  out  2  number of non-IDLE slots.
- expl_valid  out  1  explosion event pending toward map-update stage.
- expl_addr  out  ADDR_WIDTH  event centre tile.
- expl_range  out  2  event range.
- expl_ready  in  1  consumer accepts event.

Function
REQ-003 Player tile SHALL be col=(player_x+SPRITE_W/2)>>log2(TILE_PX), row=(player_y+SPRITE_H/2)>>log2(TILE_PX), addr=row*NUM_COL+col, computed at full width before truncation to ADDR_WIDTH.
REQ-004 Each of 3 slots SHALL hold state IDLE/ARMED/EXPLODING, addr, latched range, tick timer, pending flag.
REQ-005 Placement SHALL be accepted in a cycle when place_req=1, bomb_count<max_bombs, and no non-IDLE slot holds the same addr; else ignored with no state change.
REQ-006 An accepted placement SHALL load the lowest-index IDLE slot next cycle: ARMED, timer=BOMB_TIME, range=bomb_range sampled that cycle, pending=0.
REQ-007 Holding place_req high SHALL place at most one bomb per tile (REQ-005 duplicate rule blocks repeats).
REQ-008 ARMED with tick: timer>1 -> decrement; timer==1 -> EXPLODING, timer=EXPLODE_TIME, pending=1.
REQ-009 A slot loaded in the same cycle as a tick SHALL NOT be decremented by that tick.
REQ-010 EXPLODING with tick SHALL decrement timer while >0; slot SHALL return to IDLE in the first cycle where timer==0 and pending==0.
REQ-011 expl_valid/expl_addr/expl_range SHALL be registered; present the lowest-index pending slot; remain stable while expl_valid=1 and expl_ready=0.
REQ-012 Transfer occurs when expl_valid&&expl_ready; that slot's pending SHALL clear; next pending event SHALL appear no earlier than the following cycle.
REQ-013 Simultaneous detonations SHALL each produce exactly one event, delivered in ascending slot order; no event lost or duplicated.
REQ-014 bomb_count, bomb_active, explode_active, bomb_addr SHALL reflect registered slot state; bomb_addr of IDLE slot SHALL be 0.
REQ-015 max_bombs lowered below bomb_count SHALL not cancel existing bombs; only blocks new placements.

Reset
REQ-016 rst=1 SHALL force all slots IDLE, timers/pending/addr 0, expl_valid=0, expl_addr=0, expl_range=0, bomb_count=0, all per-slot outputs 0 next cycle.
REQ-017 rst mid-operation SHALL discard armed bombs and undelivered events; rst overrides place_req and tick in the same cycle.

Verification
REQ-018 Bench SHALL cover:
- Place at (100,50), max_bombs=1, range=2 -> slot0 ARMED, bomb_addr[0]=20, bomb_count=1; 3 ticks later explode_active[0]=1, expl_valid=1, expl_addr=20, expl_range=2.
- max_bombs=1, bomb armed, move to (228,50), place -> ignored, bomb_count stays 1; max_bombs=2 -> placement to addr 22 in slot1.
- place_req held 10 cycles on same tile, max_bombs=3 -> exactly one slot ARMED.
- Two bombs placed same cycle-window, same tick expiry, expl_ready=0 for 5 cycles -> expl_addr of slot0 stable; ready=1 -> slot0 then slot1 events, one each; slots IDLE only after delivery and EXPLODE_TIME.
- Placement coincident with tick -> timer=3 unchanged that cycle; detonation on 3rd subsequent tick.
- rst asserted with 2 armed bombs and expl_valid=1 -> next cycle all outputs 0, no further events.
